// File: rtl/register_file_pkg.sv
// ---------------------------------------------------------------------------
// register_file_pkg
// Purpose : Shared defaults and helpers for the multi-port register file.
//           Holds the default geometry constants and the helper that locates
//           one port's field inside a packed multi-port bus.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package register_file_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_READ_PORTS = 2;

  // LSB position of port `port` in a bus packing `width`-bit fields back to back.
  function automatic int slice_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/register_file_scoreboard.sv
// ---------------------------------------------------------------------------
// register_file_scoreboard
// Purpose : Per-register busy flags tracking in-flight writers, the
//           single-cycle reserve/accept handshake and the busy counter.
// Ports   : clock, resetN          - clock, async active-low reset
//           regWrite, writeRegister - writeback port (releases a reservation)
//           reserve, reserveRegister- decode request to mark a register busy
//           reserveAccept          - request taken this cycle (combinational)
//           busy                   - current busy flags, one per register
//           busyCount              - number of busy registers (registered)
// ---------------------------------------------------------------------------
module register_file_scoreboard
  import register_file_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ZERO_REG   = 0
) (
  input  logic                        clock,
  input  logic                        resetN,
  input  logic                        regWrite,
  input  logic [ADDR_WIDTH-1:0]       writeRegister,
  input  logic                        reserve,
  input  logic [ADDR_WIDTH-1:0]       reserveRegister,
  output logic                        reserveAccept,
  output logic [(2**ADDR_WIDTH)-1:0]  busy,
  output logic [ADDR_WIDTH:0]         busyCount
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DEPTH-1:0]    r_busy;
  logic [ADDR_WIDTH:0] r_count;
  logic                w_same;
  logic                w_zero_rsv;
  logic                w_inc;
  logic                w_dec;

  assign w_same     = (writeRegister == reserveRegister);
  assign w_zero_rsv = (ZERO_REG != 0) && (reserveRegister == '0);

  // A busy register may be re-reserved only when its current writer retires
  // in this very cycle; ownership then passes straight to the new writer.
  assign reserveAccept = resetN && reserve && !w_zero_rsv &&
                         (!r_busy[reserveRegister] || (regWrite && w_same));

  // The counter tracks real 0->1 and 1->0 transitions of the flags, so a
  // hand-over (clear and set on one index) and writes to idle registers
  // leave it untouched.
  assign w_inc = reserveAccept && !r_busy[reserveRegister];
  assign w_dec = resetN && regWrite && r_busy[writeRegister] &&
                 !(reserveAccept && w_same);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      if (regWrite) begin
        r_busy[writeRegister] <= 1'b0;
      end
      // Later assignment wins: a same-index set overrides the clear.
      if (reserveAccept) begin
        r_busy[reserveRegister] <= 1'b1;
      end
      if (w_inc && !w_dec) begin
        r_count <= r_count + ONE;
      end else if (w_dec && !w_inc) begin
        r_count <= r_count - ONE;
      end
    end
  end

  assign busy      = r_busy;
  assign busyCount = r_count;

endmodule

// File: rtl/register_file_multiport.sv
// ---------------------------------------------------------------------------
// register_file_multiport
// Purpose : Parameterised register file with READ_PORTS combinational read
//           ports, one write port, optional hardwired zero register,
//           optional write-to-read bypass and a busy scoreboard.
// Ports   : clock, resetN            - clock, async active-low reset
//           regWrite, writeRegister, writeData - write port
//           readRegister             - packed read indices (port p at p*ADDR_WIDTH)
//           readData                 - packed read data (port p at p*DATA_WIDTH)
//           readBusy                 - per-port: addressed register has a pending writer
//           reserve, reserveRegister - reservation request
//           reserveAccept            - reservation taken this cycle
//           busyCount                - number of busy registers
// ---------------------------------------------------------------------------
module register_file_multiport
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int READ_PORTS = DEF_READ_PORTS,
  parameter int ZERO_REG   = 0,
  parameter int BYPASS     = 1
) (
  input  logic                             clock,
  input  logic                             resetN,
  input  logic                             regWrite,
  input  logic [ADDR_WIDTH-1:0]            writeRegister,
  input  logic [DATA_WIDTH-1:0]            writeData,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] readRegister,
  output logic [READ_PORTS*DATA_WIDTH-1:0] readData,
  output logic [READ_PORTS-1:0]            readBusy,
  input  logic                             reserve,
  input  logic [ADDR_WIDTH-1:0]            reserveRegister,
  output logic                             reserveAccept,
  output logic [ADDR_WIDTH:0]              busyCount
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]      w_busy;
  logic                  w_wr_en;
  logic                  w_wr_store;
  logic [ADDR_WIDTH-1:0] w_rd_idx;

  // Gating with resetN keeps the bypass path dark while reset is held, so
  // the read ports show the cleared storage immediately.
  assign w_wr_en    = resetN && regWrite;
  assign w_wr_store = w_wr_en && !((ZERO_REG != 0) && (writeRegister == '0));

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_store) begin
      r_mem[writeRegister] <= writeData;
    end
  end

  // A forwarded value is by definition the pending writer's result, so the
  // port reports not-busy for it.
  always_comb begin
    readData = '0;
    readBusy = '0;
    w_rd_idx = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      w_rd_idx = readRegister[slice_lsb(p, ADDR_WIDTH) +: ADDR_WIDTH];
      if ((ZERO_REG != 0) && (w_rd_idx == '0)) begin
        readData[slice_lsb(p, DATA_WIDTH) +: DATA_WIDTH] = '0;
        readBusy[p] = 1'b0;
      end else if ((BYPASS != 0) && w_wr_en && (w_rd_idx == writeRegister)) begin
        readData[slice_lsb(p, DATA_WIDTH) +: DATA_WIDTH] = writeData;
        readBusy[p] = 1'b0;
      end else begin
        readData[slice_lsb(p, DATA_WIDTH) +: DATA_WIDTH] = r_mem[w_rd_idx];
        readBusy[p] = w_busy[w_rd_idx];
      end
    end
  end

  register_file_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clock           (clock),
    .resetN          (resetN),
    .regWrite        (regWrite),
    .writeRegister   (writeRegister),
    .reserve         (reserve),
    .reserveRegister (reserveRegister),
    .reserveAccept   (reserveAccept),
    .busy            (w_busy),
    .busyCount       (busyCount)
  );

endmodule

// File: tb/tb_register_file_multiport.sv
// ---------------------------------------------------------------------------
// tb_register_file_multiport
// Purpose : Self-checking bench. Two instances share one stimulus stream:
//           A = defaults (2 ports, BYPASS=1, ZERO_REG=0)
//           B = 3 ports, BYPASS=0, ZERO_REG=1
//           A driver issues directed then random cycles and queues the
//           expected outputs from an array-based model; a monitor pops and
//           compares mid-cycle.
// ---------------------------------------------------------------------------
module tb_register_file_multiport;

  logic        clock;
  logic        resetN;
  logic        regWrite;
  logic [2:0]  writeRegister;
  logic [7:0]  writeData;
  logic [2:0]  ra0, ra1, ra2;
  logic        reserve;
  logic [2:0]  reserveRegister;

  logic [5:0]  rdRegA;
  logic [8:0]  rdRegB;
  logic [15:0] rdA;
  logic [1:0]  rbA;
  logic        accA;
  logic [3:0]  cntA;
  logic [23:0] rdB;
  logic [2:0]  rbB;
  logic        accB;
  logic [3:0]  cntB;

  assign rdRegA = {ra1, ra0};
  assign rdRegB = {ra2, ra1, ra0};

  register_file_multiport dut_a (
    .clock           (clock),
    .resetN          (resetN),
    .regWrite        (regWrite),
    .writeRegister   (writeRegister),
    .writeData       (writeData),
    .readRegister    (rdRegA),
    .readData        (rdA),
    .readBusy        (rbA),
    .reserve         (reserve),
    .reserveRegister (reserveRegister),
    .reserveAccept   (accA),
    .busyCount       (cntA)
  );

  register_file_multiport #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (3),
    .READ_PORTS (3),
    .ZERO_REG   (1),
    .BYPASS     (0)
  ) dut_b (
    .clock           (clock),
    .resetN          (resetN),
    .regWrite        (regWrite),
    .writeRegister   (writeRegister),
    .writeData       (writeData),
    .readRegister    (rdRegB),
    .readData        (rdB),
    .readBusy        (rbB),
    .reserve         (reserve),
    .reserveRegister (reserveRegister),
    .reserveAccept   (accB),
    .busyCount       (cntB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] rdA;
    logic [1:0]  rbA;
    logic        accA;
    logic [3:0]  cntA;
    logic [23:0] rdB;
    logic [2:0]  rbB;
    logic        accB;
    logic [3:0]  cntB;
  } exp_t;

  exp_t exp_q [$];
  int   errors = 0;
  int   checks = 0;
  int   n_push = 0;
  int   n_pop  = 0;

  // Reference state, index 0 = instance A, 1 = instance B.
  logic [7:0] mmem  [2][8];
  bit         mbusy [2][8];

  function automatic bit is_zero_cfg(input int c);
    return (c == 1);
  endfunction

  function automatic bit is_byp_cfg(input int c);
    return (c == 0);
  endfunction

  function automatic logic [7:0] exp_data(input int c, input logic [2:0] idx);
    if (is_zero_cfg(c) && idx == 3'd0) return 8'd0;
    if (is_byp_cfg(c) && resetN && regWrite && idx == writeRegister) return writeData;
    return mmem[c][idx];
  endfunction

  function automatic logic exp_busy(input int c, input logic [2:0] idx);
    if (is_zero_cfg(c) && idx == 3'd0) return 1'b0;
    if (is_byp_cfg(c) && resetN && regWrite && idx == writeRegister) return 1'b0;
    return mbusy[c][idx];
  endfunction

  function automatic logic exp_acc(input int c);
    if (!resetN || !reserve) return 1'b0;
    if (is_zero_cfg(c) && reserveRegister == 3'd0) return 1'b0;
    return !mbusy[c][reserveRegister] || (regWrite && writeRegister == reserveRegister);
  endfunction

  function automatic logic [3:0] exp_cnt(input int c);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) if (mbusy[c][i]) n++;
    return 4'(n);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive after the edge, queue expectations, then
  // advance the model to the state after the next edge.
  task automatic step(input bit rn, input bit we, input logic [2:0] wr, input logic [7:0] wd,
                      input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2,
                      input bit rsv, input logic [2:0] rr);
    exp_t e;
    logic acc [2];
    @(posedge clock);
    #1;
    resetN = rn; regWrite = we; writeRegister = wr; writeData = wd;
    ra0 = a0; ra1 = a1; ra2 = a2; reserve = rsv; reserveRegister = rr;
    if (!rn) begin
      for (int c = 0; c < 2; c++)
        for (int i = 0; i < 8; i++) begin
          mmem[c][i]  = 8'd0;
          mbusy[c][i] = 1'b0;
        end
    end
    e.rdA  = {exp_data(0, a1), exp_data(0, a0)};
    e.rbA  = {exp_busy(0, a1), exp_busy(0, a0)};
    e.accA = exp_acc(0);
    e.cntA = exp_cnt(0);
    e.rdB  = {exp_data(1, a2), exp_data(1, a1), exp_data(1, a0)};
    e.rbB  = {exp_busy(1, a2), exp_busy(1, a1), exp_busy(1, a0)};
    e.accB = exp_acc(1);
    e.cntB = exp_cnt(1);
    exp_q.push_back(e);
    n_push++;
    acc[0] = e.accA;
    acc[1] = e.accB;
    if (rn) begin
      for (int c = 0; c < 2; c++) begin
        if (we && !(is_zero_cfg(c) && wr == 3'd0)) begin
          mmem[c][wr]  = wd;
          mbusy[c][wr] = 1'b0;
        end
        if (acc[c]) mbusy[c][rr] = 1'b1;
      end
    end
  endtask

  // Monitor: outputs are combinational or registered, stable by mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_pop++;
        chk("A.readData",      32'(rdA),  32'(e.rdA));
        chk("A.readBusy",      32'(rbA),  32'(e.rbA));
        chk("A.reserveAccept", 32'(accA), 32'(e.accA));
        chk("A.busyCount",     32'(cntA), 32'(e.cntA));
        chk("B.readData",      32'(rdB),  32'(e.rdB));
        chk("B.readBusy",      32'(rbB),  32'(e.rbB));
        chk("B.reserveAccept", 32'(accB), 32'(e.accB));
        chk("B.busyCount",     32'(cntB), 32'(e.cntB));
      end
    end
  end

  initial begin
    resetN = 1'b1; regWrite = 1'b0; writeRegister = '0; writeData = '0;
    ra0 = '0; ra1 = '0; ra2 = '0; reserve = 1'b0; reserveRegister = '0;
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 8; i++) begin
        mmem[c][i]  = 8'd0;
        mbusy[c][i] = 1'b0;
      end
    #1 resetN = 1'b0;

    // Reset state, with write and reserve requests that must be ignored.
    step(0, 1, 3'd2, 8'hAA, 3'd2, 3'd2, 3'd2, 1, 3'd3);
    step(0, 0, 3'd0, 8'h00, 3'd0, 3'd1, 3'd2, 0, 3'd0);

    // Write 3 to reg 2, read ports (0,2): bypass on A, old value on B.
    step(1, 1, 3'd2, 8'd3, 3'd0, 3'd2, 3'd2, 0, 3'd0);
    step(1, 0, 3'd0, 8'd0, 3'd0, 3'd2, 3'd2, 0, 3'd0);

    // Write 5 to reg 7 while reading it, then read again.
    step(1, 1, 3'd7, 8'd5, 3'd7, 3'd7, 3'd7, 0, 3'd0);
    step(1, 0, 3'd0, 8'd0, 3'd7, 3'd7, 3'd7, 0, 3'd0);

    // Write 9 to reg 0, then reserve reg 0 (rejected on the zero-reg file).
    step(1, 1, 3'd0, 8'd9, 3'd0, 3'd0, 3'd0, 0, 3'd0);
    step(1, 0, 3'd0, 8'd0, 3'd0, 3'd0, 3'd0, 1, 3'd0);
    step(1, 0, 3'd0, 8'd0, 3'd0, 3'd0, 3'd0, 0, 3'd0);

    // Reserve 4, reserve 4 again (rejected), write 4 releases it.
    step(1, 0, 3'd0, 8'd0, 3'd4, 3'd4, 3'd4, 1, 3'd4);
    step(1, 0, 3'd0, 8'd0, 3'd4, 3'd4, 3'd4, 1, 3'd4);
    step(1, 1, 3'd4, 8'h44, 3'd4, 3'd4, 3'd4, 0, 3'd0);
    step(1, 0, 3'd0, 8'd0, 3'd4, 3'd4, 3'd4, 0, 3'd0);

    // Hand-over: reserve and write reg 4 in the same cycle while busy.
    step(1, 0, 3'd0, 8'd0, 3'd4, 3'd4, 3'd4, 1, 3'd4);
    step(1, 1, 3'd4, 8'h66, 3'd4, 3'd4, 3'd4, 1, 3'd4);
    step(1, 0, 3'd0, 8'd0, 3'd4, 3'd5, 3'd4, 0, 3'd0);

    // Write to a non-busy register leaves busy state alone.
    step(1, 1, 3'd6, 8'h77, 3'd6, 3'd4, 3'd6, 0, 3'd0);

    // Reserve every register, then drop reset between edges.
    for (int i = 0; i < 8; i++)
      step(1, 0, 3'd0, 8'd0, 3'(i), 3'd4, 3'd7, 1, 3'(i));
    step(1, 0, 3'd0, 8'd0, 3'd2, 3'd4, 3'd7, 0, 3'd0);
    step(0, 0, 3'd0, 8'd0, 3'd2, 3'd4, 3'd7, 0, 3'd0);
    step(1, 0, 3'd0, 8'd0, 3'd2, 3'd4, 3'd7, 0, 3'd0);

    // Random traffic with occasional mid-sequence resets.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) != 0),
           1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)),
           8'($urandom),
           3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)));
    end

    @(posedge clock);
    @(posedge clock);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("pop_count", 32'(n_pop), 32'(n_push));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
